transpose_stream: RTL and testbench
===================================

Name: transpose_stream

Overview:
- Runtime-configurable matrix transpose buffer with valid/ready streaming on both sides.
- Accepts M row vectors of N lanes and emits N column vectors of M lanes, with M ≤ ROW_DIM and N ≤ COL_DIM.
- Sits between the on-chip buffer read path and the PE array feeder.
- Replaces the fixed-timing transpose with handshakes, per-job dimensions, config checking and done signalling.

Parameters:
ROW_DIM, 16, max rows per job; lane count of output vector
COL_DIM, 16, max columns per job; lane count of input vector
DATA_WIDTH, 8, bits per element

Ports:
clk  input  1  clock; all state on rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  job start pulse, sampled only in IDLE
cfg_rows  input  $clog2(ROW_DIM)+1  M, rows in job, legal 1..ROW_DIM
cfg_cols  input  $clog2(COL_DIM)+1  N, columns in job, legal 1..COL_DIM
in_valid  input  1  in_data valid
in_ready  output  1  block accepts a row
in_data  input  COL_DIM*DATA_WIDTH  row vector; lane c at bits [DATA_WIDTH*(c+1)-1 : DATA_WIDTH*c]
out_valid  output  1  out_data valid
out_ready  input  1  consumer accepts a column
out_data  output  ROW_DIM*DATA_WIDTH  column vector; lane r = element (r, j)
busy  output  1  state != IDLE
done  output  1  one-cycle pulse at job completion
cfg_err  output  1  one-cycle pulse when start carries an illegal config

Behaviour:
- Reset (reset=0, async): state=IDLE; row/col counters=0; all buffer elements=0; in_ready=out_valid=busy=done=cfg_err=0; out_data=0.
- Storage: ROW_DIM x COL_DIM element register array. M and N are latched at start; cfg_* is ignored afterwards.
- IDLE:
  - start with 1≤cfg_rows≤ROW_DIM and 1≤cfg_cols≤COL_DIM: latch config, counters=0, go to LOAD next cycle.
  - start with illegal config: cfg_err=1 for the next cycle; stay IDLE.
  - No start: stay IDLE.
- LOAD:
  - in_ready=1.
  - Beat k (in_valid&in_ready) writes lanes 0..N-1 into buffer row k; lanes ≥N are not written. k increments.
  - On beat M-1 go to DRAIN next cycle. in_ready=0 from that cycle on.
- DRAIN:
  - out_valid=1.
  - out_data lane r = buf[r][j] for r<M, where j is the registered column counter.
  - Handshake (out_valid&out_ready) increments j.
  - out_data is held stable while out_valid&!out_ready.
  - On handshake with j=N-1: go to IDLE, done=1 for the next cycle, out_valid=0.
- Latency: first out_valid is the cycle after the last input handshake. Zero-bubble throughput of 1 beat/cycle per phase.
- start is ignored while busy. in_valid outside LOAD is ignored (no write). out_ready outside DRAIN is ignored.
- done and a new start may coincide. done is in IDLE, so that start is accepted.
- M=1 or N=1 are legal. Single-beat phases follow the same transitions.
- Buffer contents persist across jobs (not cleared between jobs).
- Reset mid-job aborts immediately. No done pulse; the next job behaves as from power-up.

Optional Feature:
TRANSPOSE_ZERO_PAD_EN
- Defined: out_data lanes r ≥ M are forced to 0 in DRAIN.
- Not defined: lanes r ≥ M carry the current contents of buf[r][j]. These may be stale from earlier jobs, and the bench masks them.
- In-range lanes are identical in both builds.

Test Plan:
1. M=16, N=16, row k lane c = k*16+c, in_valid/out_ready held 1.
   - Out beat j lane r = r*16+j for all 16 beats, back-to-back.
   - done pulses 1 cycle after the 16th out handshake.
   - busy is high from the cycle after start until done.
2. M=3, N=5, in row k lane c = 0x10*k+c.
   - Exactly 3 in handshakes, then 5 out beats; beat j lanes 0..2 = {j, 0x10+j, 0x20+j}.
   - With TRANSPOSE_ZERO_PAD_EN, lanes 3..15 = 0.
3. Same job as 1 with out_ready pattern 1,0,0,1 repeating.
   - out_data unchanged during stalls; 16 distinct beats in order; none lost or duplicated.
4. in_valid pattern 1,0,1,1,0 repeating during LOAD.
   - Writes only on valid cycles; output identical to scenario 1.
5. Illegal configs.
   - start with cfg_rows=0: cfg_err=1 one cycle, busy stays 0.
   - start with cfg_cols=17: same response.
   - A following legal start completes normally.
6. Reset mid-op: assert reset=0 after 4 out beats of job 1.
   - out_valid/busy drop to 0 asynchronously; no done pulse.
   - After release, new job 2 (M=2, N=2) yields correct transposed output.

Source files
------------

// File: rtl/transpose_stream.sv
// transpose_stream: streaming matrix transpose buffer.
// Accepts M row vectors of N lanes over a valid/ready input port and
// replays them as N column vectors of M lanes over a valid/ready output port.
// Optional build macro TRANSPOSE_ZERO_PAD_EN: out_data lanes r >= M are
// forced to zero while draining; otherwise they show stale buffer contents.
module transpose_stream #(
  parameter int ROW_DIM    = 16,
  parameter int COL_DIM    = 16,
  parameter int DATA_WIDTH = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [$clog2(ROW_DIM):0]       cfg_rows,
  input  logic [$clog2(COL_DIM):0]       cfg_cols,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [COL_DIM*DATA_WIDTH-1:0]  in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [ROW_DIM*DATA_WIDTH-1:0]  out_data,
  output logic                           busy,
  output logic                           done,
  output logic                           cfg_err
);

  localparam int RW = $clog2(ROW_DIM) + 1;
  localparam int CW = $clog2(COL_DIM) + 1;
  localparam int RI = (ROW_DIM > 1) ? $clog2(ROW_DIM) : 1;
  localparam int CI = (COL_DIM > 1) ? $clog2(COL_DIM) : 1;

  localparam logic [RW-1:0] ROW_ONE = RW'(1);
  localparam logic [RW-1:0] ROW_MAX = RW'(ROW_DIM);
  localparam logic [CW-1:0] COL_ONE = CW'(1);
  localparam logic [CW-1:0] COL_MAX = CW'(COL_DIM);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t                  state_r;
  logic [RW-1:0]           rows_r;
  logic [CW-1:0]           cols_r;
  logic [RW-1:0]           row_cnt_r;
  logic [CW-1:0]           col_cnt_r;
  logic [DATA_WIDTH-1:0]   buf_r [ROW_DIM][COL_DIM];

  logic                          cfg_ok_s;
  logic                          last_row_s;
  logic                          last_col_s;
  logic [CW-1:0]                 nxt_col_s;
  logic                          pad_s;
  logic [ROW_DIM*DATA_WIDTH-1:0] first_col_s;
  logic [ROW_DIM*DATA_WIDTH-1:0] next_col_s;

  // Config legality and end-of-phase detection from the latched dimensions.
  always_comb begin
    cfg_ok_s   = (cfg_rows >= ROW_ONE) && (cfg_rows <= ROW_MAX) &&
                 (cfg_cols >= COL_ONE) && (cfg_cols <= COL_MAX);
    last_row_s = (row_cnt_r == (rows_r - ROW_ONE));
    last_col_s = (col_cnt_r == (cols_r - COL_ONE));
    nxt_col_s  = col_cnt_r + COL_ONE;
  end

  // Column vectors to load into out_data: column 0 (including the row being
  // written on the final load beat) and column j+1 for the next drain beat.
  always_comb begin
    first_col_s = '0;
    next_col_s  = '0;
    pad_s       = 1'b0;
    for (int r = 0; r < ROW_DIM; r++) begin
`ifdef TRANSPOSE_ZERO_PAD_EN
      pad_s = (RW'(r) >= rows_r);
`else
      pad_s = 1'b0;
`endif
      if (pad_s) begin
        first_col_s[r*DATA_WIDTH +: DATA_WIDTH] = '0;
        next_col_s[r*DATA_WIDTH +: DATA_WIDTH]  = '0;
      end else begin
        if (RW'(r) == row_cnt_r) begin
          first_col_s[r*DATA_WIDTH +: DATA_WIDTH] = in_data[DATA_WIDTH-1:0];
        end else begin
          first_col_s[r*DATA_WIDTH +: DATA_WIDTH] = buf_r[r][0];
        end
        next_col_s[r*DATA_WIDTH +: DATA_WIDTH] = buf_r[r][nxt_col_s[CI-1:0]];
      end
    end
  end

  // Job FSM, buffer writes and all registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= ST_IDLE;
      rows_r    <= '0;
      cols_r    <= '0;
      row_cnt_r <= '0;
      col_cnt_r <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cfg_err   <= 1'b0;
      for (int r = 0; r < ROW_DIM; r++) begin
        for (int c = 0; c < COL_DIM; c++) begin
          buf_r[r][c] <= '0;
        end
      end
    end else begin
      done    <= 1'b0;
      cfg_err <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            if (cfg_ok_s) begin
              rows_r    <= cfg_rows;
              cols_r    <= cfg_cols;
              row_cnt_r <= '0;
              col_cnt_r <= '0;
              in_ready  <= 1'b1;
              busy      <= 1'b1;
              state_r   <= ST_LOAD;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          // in_ready is high throughout LOAD, so in_valid alone marks a beat
          if (in_valid) begin
            for (int c = 0; c < COL_DIM; c++) begin
              if (CW'(c) < cols_r) begin
                buf_r[row_cnt_r[RI-1:0]][c] <= in_data[c*DATA_WIDTH +: DATA_WIDTH];
              end
            end
            if (last_row_s) begin
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              out_data  <= first_col_s;
              col_cnt_r <= '0;
              state_r   <= ST_DRAIN;
            end else begin
              row_cnt_r <= row_cnt_r + ROW_ONE;
            end
          end
        end
        ST_DRAIN: begin
          if (out_ready) begin
            if (last_col_s) begin
              out_valid <= 1'b0;
              out_data  <= '0;
              busy      <= 1'b0;
              done      <= 1'b1;
              state_r   <= ST_IDLE;
            end else begin
              col_cnt_r <= nxt_col_s;
              out_data  <= next_col_s;
            end
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_transpose_stream.sv
// Directed, table-driven bench for transpose_stream (16x16, 8-bit elements).
module tb_transpose_stream;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [4:0]   cfg_rows;
  logic [4:0]   cfg_cols;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;
  logic         done;
  logic         cfg_err;

  int n_total = 0;
  int n_pass  = 0;

  transpose_stream #(.ROW_DIM(16), .COL_DIM(16), .DATA_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .start(start),
    .cfg_rows(cfg_rows), .cfg_cols(cfg_cols),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         m;
    int         n;
    logic [7:0] base;
    logic [4:0] vpat;   // in_valid pattern, bit t%5 used on load cycle t
    logic [3:0] rpat;   // out_ready pattern, bit t%4 used on drain cycle t
    logic       exp_err;
  } job_t;

  job_t tbl [11];

  task automatic chkv(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %b expected %b", nm, act, exp);
    else n_pass++;
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    n_total++;
    if (act != exp) $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    else n_pass++;
  endtask

  // Element (k, c) of a job is base + 16*k + c (mod 256).
  function automatic logic [127:0] row_vec(input int k, input int n, input logic [7:0] base);
    logic [127:0] v;
    for (int c = 0; c < 16; c++) begin
      v[c*8 +: 8] = (c < n) ? (base + 8'(k*16 + c)) : 8'hEE;
    end
    return v;
  endfunction

  function automatic logic [127:0] exp_col(input int m, input int j, input logic [7:0] base);
    logic [127:0] v;
    for (int r = 0; r < 16; r++) begin
      v[r*8 +: 8] = (r < m) ? (base + 8'(r*16 + j)) : 8'h00;
    end
    return v;
  endfunction

  function automatic logic [127:0] lane_mask(input int m);
    logic [127:0] v;
    for (int r = 0; r < 16; r++) begin
`ifdef TRANSPOSE_ZERO_PAD_EN
      v[r*8 +: 8] = 8'hFF;
`else
      v[r*8 +: 8] = (r < m) ? 8'hFF : 8'h00;
`endif
    end
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int m, input int n);
    cfg_rows = 5'(m);
    cfg_cols = 5'(n);
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  // Feed M rows; start/cfg/out_ready are wiggled to show they are ignored.
  task automatic load_rows(input int m, input int n, input logic [7:0] base, input logic [4:0] vpat);
    int k = 0;
    int t = 0;
    start = 1'b1; cfg_rows = 5'd1; cfg_cols = 5'd1; out_ready = 1'b1;
    while (k < m && t < 200) begin
      chk1("load_in_ready", in_ready, 1'b1);
      chk1("load_out_valid", out_valid, 1'b0);
      in_valid = vpat[t % 5];
      in_data  = in_valid ? row_vec(k, n, base) : {16{8'hA5}};
      tick();
      if (in_valid) k++;
      t++;
    end
    in_valid = 1'b0; start = 1'b0; out_ready = 1'b0;
    chki("load_beats", k, m);
    chk1("drain_entry_in_ready", in_ready, 1'b0);
    chk1("drain_entry_out_valid", out_valid, 1'b1);
    chk1("drain_entry_busy", busy, 1'b1);
  endtask

  // Consume `stop` columns; junk on the input side must not be written.
  task automatic drain_cols(input int m, input int n, input logic [7:0] base,
                            input logic [3:0] rpat, input int stop);
    int j = 0;
    int t = 0;
    start = 1'b1; in_valid = 1'b1; in_data = {16{8'hFF}};
    while (j < stop && t < 400) begin
      chk1("drain_out_valid", out_valid, 1'b1);
      chk1("drain_in_ready", in_ready, 1'b0);
      chk1("drain_done_low", done, 1'b0);
      chkv("drain_data", out_data & lane_mask(m), exp_col(m, j, base));
      out_ready = rpat[t % 4];
      tick();
      if (out_ready) j++;
      t++;
    end
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chki("drain_beats", j, stop);
    if (stop == n) begin
      chk1("done_pulse", done, 1'b1);
      chk1("done_busy", busy, 1'b0);
      chk1("done_out_valid", out_valid, 1'b0);
    end
  endtask

  initial begin
    tbl[0]  = '{16, 16, 8'h00, 5'b11111, 4'b1111, 1'b0};
    tbl[1]  = '{3,  5,  8'h00, 5'b11111, 4'b1111, 1'b0};
    tbl[2]  = '{16, 16, 8'h00, 5'b11111, 4'b1001, 1'b0};
    tbl[3]  = '{16, 16, 8'h00, 5'b01101, 4'b1111, 1'b0};
    tbl[4]  = '{1,  1,  8'h55, 5'b11111, 4'b1111, 1'b0};
    tbl[5]  = '{1,  16, 8'h20, 5'b01101, 4'b1111, 1'b0};
    tbl[6]  = '{16, 1,  8'h30, 5'b11111, 4'b1001, 1'b0};
    tbl[7]  = '{0,  4,  8'h00, 5'b11111, 4'b1111, 1'b1};
    tbl[8]  = '{4,  17, 8'h00, 5'b11111, 4'b1111, 1'b1};
    tbl[9]  = '{17, 4,  8'h00, 5'b11111, 4'b1111, 1'b1};
    tbl[10] = '{7,  3,  8'h90, 5'b01101, 4'b1001, 1'b0};

    reset = 1'b0; start = 1'b0; cfg_rows = 5'd0; cfg_cols = 5'd0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk1("rst_in_ready", in_ready, 1'b0);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_cfg_err", cfg_err, 1'b0);
    chkv("rst_out_data", out_data, 128'd0);
    reset = 1'b1;
    tick();

    for (int i = 0; i < 11; i++) begin
      do_start(tbl[i].m, tbl[i].n);
      if (tbl[i].exp_err) begin
        chk1("err_pulse", cfg_err, 1'b1);
        chk1("err_busy", busy, 1'b0);
        chk1("err_in_ready", in_ready, 1'b0);
        tick();
        chk1("err_pulse_end", cfg_err, 1'b0);
        chk1("err_busy_after", busy, 1'b0);
      end else begin
        chk1("start_busy", busy, 1'b1);
        chk1("start_cfg_err", cfg_err, 1'b0);
        load_rows(tbl[i].m, tbl[i].n, tbl[i].base, tbl[i].vpat);
        drain_cols(tbl[i].m, tbl[i].n, tbl[i].base, tbl[i].rpat, tbl[i].n);
        tick();
        chk1("done_one_cycle", done, 1'b0);
      end
    end

    // A start issued in the done cycle is accepted.
    do_start(2, 3);
    load_rows(2, 3, 8'h11, 5'b11111);
    drain_cols(2, 3, 8'h11, 4'b1111, 3);
    do_start(3, 2);
    chk1("b2b_busy", busy, 1'b1);
    chk1("b2b_done_end", done, 1'b0);
    load_rows(3, 2, 8'h61, 5'b11111);
    drain_cols(3, 2, 8'h61, 4'b1111, 2);
    tick();

    // Reset in the middle of a drain, then a fresh small job.
    do_start(16, 16);
    load_rows(16, 16, 8'h00, 5'b11111);
    drain_cols(16, 16, 8'h00, 4'b1111, 4);
    reset = 1'b0;
    #1;
    chk1("abort_out_valid", out_valid, 1'b0);
    chk1("abort_busy", busy, 1'b0);
    chk1("abort_in_ready", in_ready, 1'b0);
    chkv("abort_out_data", out_data, 128'd0);
    tick();
    chk1("abort_no_done", done, 1'b0);
    reset = 1'b1;
    tick();
    chk1("abort_no_done2", done, 1'b0);
    chk1("abort_idle", busy, 1'b0);
    do_start(2, 2);
    chk1("post_rst_busy", busy, 1'b1);
    load_rows(2, 2, 8'h40, 5'b11111);
    drain_cols(2, 2, 8'h40, 4'b1111, 2);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
